// File: rtl/nibble_link_pkg.sv
// rtl/nibble_link_pkg.sv - shared types and sizes for both ends of the 4-bit nibble link
package nibble_link_pkg;

    localparam int NIBBLE_W    = 4;
    localparam int DATA_W_DEF  = 32;
    localparam int NIBBLES_DEF = DATA_W_DEF / NIBBLE_W;
    localparam int IDX_W_DEF   = $clog2(NIBBLES_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SEND = 2'b01,
        GAP  = 2'b10
    } state_t;

endpackage

// File: rtl/nibble_link_tx_if.sv
// rtl/nibble_link_tx_if.sv - word-side valid/ready handshake into the nibble link transmitter
interface nibble_link_tx_if #(
    parameter int DATA_W = 32
);

    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] tx_data;

    modport master (output tx_valid, output tx_data, input tx_ready);
    modport slave  (input tx_valid, input tx_data, output tx_ready);

endinterface

// File: rtl/nibble_link_timer.sv
// rtl/nibble_link_timer.sv - loadable down-counter that stops at zero and flags it
module nibble_link_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/nibble_link_tx.sv
// rtl/nibble_link_tx.sv - serialises one word LS nibble first, each nibble held until rx_ack
module nibble_link_tx
    import nibble_link_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int NIBBLES    = DATA_W / NIBBLE_W,
    parameter int IDX_W      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1,
    parameter int GAP_CYCLES = 1,
    parameter int TIMEOUT    = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    nibble_link_tx_if.slave     s_word,
    output logic [NIBBLE_W-1:0] o_tx_nibble,
    output logic                o_tx_strobe,
    input  logic                i_rx_ack,
    output logic [IDX_W-1:0]    o_nib_idx,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    // Timers hold N-1 so that zero marks the final cycle of the window.
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t              r_state, w_state_nxt;
    logic [DATA_W-1:0]   r_shift, w_shift_nxt;
    logic [NIBBLE_W-1:0] r_nibble, w_nibble_nxt;
    logic                r_strobe, w_strobe_nxt;
    logic [IDX_W-1:0]    r_idx, w_idx_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_done, w_done_nxt;
    logic                r_err, w_err_nxt;

    logic w_accept, w_ack, w_last, w_abort, w_gap_exp;
    logic w_gap_zero, w_to_zero;

    assign w_accept  = (r_state == IDLE) && s_word.tx_valid;
    assign w_ack     = (r_state == SEND) && i_rx_ack;
    assign w_last    = (r_idx == IDX_W'(NIBBLES - 1));
    assign w_abort   = (r_state == SEND) && !i_rx_ack && (TIMEOUT != 0) && w_to_zero;
    assign w_gap_exp = (r_state == GAP) && w_gap_zero;

    nibble_link_timer #(.W(GAP_W)) u_gap_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_ack && !w_last),
        .i_load_val (GAP_LOAD),
        .i_dec      (r_state == GAP),
        .o_zero     (w_gap_zero)
    );

    nibble_link_timer #(.W(TO_W)) u_to_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_accept || w_gap_exp),
        .i_load_val (TO_LOAD),
        .i_dec      ((r_state == SEND) && !i_rx_ack),
        .o_zero     (w_to_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_nibble <= '0;
            r_strobe <= 1'b0;
            r_idx    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_shift  <= w_shift_nxt;
            r_nibble <= w_nibble_nxt;
            r_strobe <= w_strobe_nxt;
            r_idx    <= w_idx_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_accept) w_state_nxt = SEND;
            SEND: begin
                if (w_ack) w_state_nxt = w_last ? IDLE : GAP;
                else if (w_abort) w_state_nxt = IDLE;
            end
            GAP:  if (w_gap_exp) w_state_nxt = SEND;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_shift_nxt  = r_shift;
        w_nibble_nxt = r_nibble;
        w_strobe_nxt = r_strobe;
        w_idx_nxt    = r_idx;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_err_nxt    = 1'b0;
        if (w_accept) begin
            w_shift_nxt  = s_word.tx_data;
            w_nibble_nxt = s_word.tx_data[NIBBLE_W-1:0];
            w_strobe_nxt = 1'b1;
            w_idx_nxt    = '0;
            w_busy_nxt   = 1'b1;
        end else if (w_ack) begin
            w_strobe_nxt = 1'b0;
            if (w_last) begin
                w_busy_nxt = 1'b0;
                w_done_nxt = 1'b1;
                w_idx_nxt  = '0;
            end else begin
                w_shift_nxt = r_shift >> NIBBLE_W;
                w_idx_nxt   = r_idx + 1'b1;
            end
        end else if (w_abort) begin
            w_strobe_nxt = 1'b0;
            w_err_nxt    = 1'b1;
            w_busy_nxt   = 1'b0;
            w_idx_nxt    = '0;
        end else if (w_gap_exp) begin
            w_nibble_nxt = r_shift[NIBBLE_W-1:0];
            w_strobe_nxt = 1'b1;
        end
    end

    assign s_word.tx_ready = (r_state == IDLE);
    assign o_tx_nibble     = r_nibble;
    assign o_tx_strobe     = r_strobe;
    assign o_nib_idx       = r_idx;
    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_err           = r_err;

endmodule

// File: tb/tb_nibble_link_tx.sv
// tb/tb_nibble_link_tx.sv - directed self-checking bench for nibble_link_tx
module tb_nibble_link_tx;
    import nibble_link_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_ack = 1'b0;
    logic [3:0] nib;
    logic       strobe;
    logic [2:0] idx;
    logic       busy, done, err;

    nibble_link_tx_if #(.DATA_W(32)) word_if ();

    nibble_link_tx #(
        .DATA_W     (32),
        .GAP_CYCLES (1),
        .TIMEOUT    (10)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_word      (word_if),
        .o_tx_nibble (nib),
        .o_tx_strobe (strobe),
        .i_rx_ack    (rx_ack),
        .o_nib_idx   (idx),
        .o_busy      (busy),
        .o_done      (done),
        .o_err       (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // receiver model and monitor state
    int   cyc = 0;
    int   s_cnt = 0;
    int   last_run = 0;
    bit   rx_on = 1'b0;
    int   ack_at = 2;
    int   late_idx = -1;
    int   late_extra = 0;
    int   late_hi = 0;
    int   late_bad = 0;
    bit   spur_idle = 1'b0;
    bit   spur_gap = 1'b0;
    logic prev_strobe = 1'b0;
    int   done_cnt = 0;
    int   err_cnt = 0;
    logic [3:0] nib_q[$];
    int         idx_q[$];
    int         rise_cyc_q[$];
    int         done_cyc_q[$];

    // ack is raised once the strobe has been seen ack_at cycles, giving a 3-cycle nibble
    always @(negedge clk) begin
        cyc++;
        if (strobe) begin
            s_cnt++;
        end else begin
            if (s_cnt != 0) last_run = s_cnt;
            s_cnt = 0;
        end
        if (strobe && !prev_strobe) begin
            nib_q.push_back(nib);
            idx_q.push_back(int'(idx));
            rise_cyc_q.push_back(cyc);
        end
        if (strobe && int'(idx) == late_idx) begin
            late_hi++;
            if (nib != 4'h5) late_bad++;
        end
        if (done) begin
            done_cnt++;
            done_cyc_q.push_back(cyc);
        end
        if (err) err_cnt++;
        prev_strobe = strobe;
        rx_ack = (rx_on && strobe &&
                  s_cnt == ack_at + ((int'(idx) == late_idx) ? late_extra : 0))
                 || spur_idle || (spur_gap && busy && !strobe);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        nib_q.delete();
        idx_q.delete();
        rise_cyc_q.delete();
    endtask

    task automatic send(input logic [31:0] d);
        word_if.tx_data  = d;
        word_if.tx_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (word_if.tx_ready) begin
                tick();
                word_if.tx_valid = 1'b0;
                return;
            end
            tick();
        end
        word_if.tx_valid = 1'b0;
        check("accept_timeout", 0, 1);
    endtask

    task automatic wait_end(input string tag);
        for (int i = 0; i < 200; i++) begin
            if (done || err) return;
            tick();
        end
        check({tag, "_end_timeout"}, 0, 1);
    endtask

    task automatic expect_word(input string tag, input logic [31:0] d, input int base);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s_nib%0d", tag, i), 64'(nib_q[base+i]), 64'(d[4*i +: 4]));
            check($sformatf("%s_idx%0d", tag, i), 64'(idx_q[base+i]), 64'(i));
        end
    endtask

    int nd, dc, ec;

    initial begin
        word_if.tx_valid = 1'b0;
        word_if.tx_data  = '0;
        tick();
        tick();
        check("rst_strobe", 64'(strobe), 0);
        check("rst_nibble", 64'(nib), 0);
        check("rst_idx", 64'(idx), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);
        check("rst_err", 64'(err), 0);
        rst_n = 1'b1;
        tick();
        check("rst_ready", 64'(word_if.tx_ready), 1);

        // nominal word, first strobe one cycle after acceptance, done in the word's 24th cycle
        rx_on = 1'b1;
        clear_mon();
        send(32'h1234_5678);
        check("t1_first_strobe", 64'(strobe), 1);
        check("t1_first_nib", 64'(nib), 8);
        check("t1_ready_low", 64'(word_if.tx_ready), 0);
        wait_end("t1");
        check("t1_done", 64'(done), 1);
        check("t1_ready_with_done", 64'(word_if.tx_ready), 1);
        check("t1_busy_off", 64'(busy), 0);
        tick();
        check("t1_done_one_cycle", 64'(done), 0);
        tick();
        check("t1_rises", 64'(nib_q.size()), 8);
        expect_word("t1", 32'h1234_5678, 0);
        check("t1_latency", 64'(done_cyc_q[0] - rise_cyc_q[0]), 23);
        check("t1_done_cnt", 64'(done_cnt), 1);
        check("t1_err_cnt", 64'(err_cnt), 0);

        // late ack on the third nibble (index 2, value 5)
        late_idx = 2;
        late_extra = 5;
        late_hi = 0;
        late_bad = 0;
        clear_mon();
        send(32'hA5A5_A5A5);
        wait_end("t2");
        check("t2_done", 64'(done), 1);
        tick();
        late_idx = -1;
        check("t2_rises", 64'(nib_q.size()), 8);
        expect_word("t2", 32'hA5A5_A5A5, 0);
        check("t2_hold_cycles", 64'(late_hi), 7);
        check("t2_hold_stable", 64'(late_bad), 0);
        check("t2_err_cnt", 64'(err_cnt), 0);
        check("t2_done_cnt", 64'(done_cnt), 2);

        // receiver silent: abort after 10 strobe cycles
        rx_on = 1'b0;
        clear_mon();
        send(32'h0BAD_CAFE);
        wait_end("t3");
        check("t3_err", 64'(err), 1);
        check("t3_no_done", 64'(done), 0);
        check("t3_busy", 64'(busy), 0);
        check("t3_ready", 64'(word_if.tx_ready), 1);
        check("t3_strobe_low", 64'(strobe), 0);
        check("t3_strobe_run", 64'(last_run), 10);
        check("t3_idx", 64'(idx), 0);
        tick();
        check("t3_err_one_cycle", 64'(err), 0);
        check("t3_err_cnt", 64'(err_cnt), 1);
        check("t3_done_cnt", 64'(done_cnt), 2);
        check("t3_rises", 64'(nib_q.size()), 1);
        rx_on = 1'b1;

        // stray acks while idle and in every gap
        clear_mon();
        spur_idle = 1'b1;
        tick();
        tick();
        tick();
        spur_idle = 1'b0;
        tick();
        tick();
        check("t4_idle_busy", 64'(busy), 0);
        check("t4_idle_strobe", 64'(strobe), 0);
        check("t4_idle_idx", 64'(idx), 0);
        check("t4_idle_rises", 64'(nib_q.size()), 0);
        check("t4_idle_err", 64'(err_cnt), 1);
        spur_gap = 1'b1;
        send(32'h1234_5678);
        wait_end("t4");
        check("t4_done", 64'(done), 1);
        spur_gap = 1'b0;
        tick();
        check("t4_rises", 64'(nib_q.size()), 8);
        expect_word("t4", 32'h1234_5678, 0);
        check("t4_err_cnt", 64'(err_cnt), 1);

        // reset in the middle of a word
        clear_mon();
        send(32'hCAFE_F00D);
        for (int i = 0; i < 100; i++) begin
            if (strobe && idx == 3'd4) break;
            tick();
        end
        check("t5_reached_idx4", 64'(strobe && idx == 3'd4), 1);
        dc = done_cnt;
        ec = err_cnt;
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_strobe_async", 64'(strobe), 0);
        check("t5_busy_async", 64'(busy), 0);
        check("t5_idx_async", 64'(idx), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("t5_no_done", 64'(done_cnt), 64'(dc));
        check("t5_no_err", 64'(err_cnt), 64'(ec));
        clear_mon();
        send(32'hDEAD_BEEF);
        check("t5_first_nib", 64'(nib), 4'hF);
        wait_end("t5");
        check("t5_done", 64'(done), 1);
        tick();
        expect_word("t5", 32'hDEAD_BEEF, 0);

        // back-to-back with tx_valid held
        clear_mon();
        nd = done_cyc_q.size();
        word_if.tx_data  = 32'h0000_0001;
        word_if.tx_valid = 1'b1;
        check("t6_ready", 64'(word_if.tx_ready), 1);
        tick();
        word_if.tx_data = 32'hFFFF_FFFF;
        wait_end("t6a");
        check("t6_done_a", 64'(done), 1);
        tick();
        word_if.tx_valid = 1'b0;
        check("t6_second_accepted", 64'(busy), 1);
        wait_end("t6b");
        check("t6_done_b", 64'(done), 1);
        tick();
        check("t6_rises", 64'(nib_q.size()), 16);
        expect_word("t6a", 32'h0000_0001, 0);
        expect_word("t6b", 32'hFFFF_FFFF, 8);
        check("t6_accept_after_done", 64'(rise_cyc_q[8]), 64'(done_cyc_q[nd] + 1));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
